dbuf_load_ctrl: RTL and testbench
=================================

DBUF_LOAD_CTRL -- requirements
Module: dbuf_load_ctrl

Interface
REQ-001 SHALL have parameter PE_NUM, default 32, meaning PE count and width of the mask.
REQ-002 SHALL have parameter DDR_ADDR_W, default 32, meaning DDR byte-address width.
REQ-003 SHALL have parameter TILE_W, default 8, meaning tile-count width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have task port: task_valid in 1, task_ready out 1, task_mode in 4, task_ch_num in 4, task_row_num in 4, task_pix_num in 4, task_mask in PE_NUM, task_depool in 1, task_addr1 in DDR_ADDR_W, task_addr2 in DDR_ADDR_W, task_stride in DDR_ADDR_W, task_tile_num in TILE_W (tiles minus one).
REQ-006 SHALL have read-request ports rdN_req_valid out 1, rdN_req_ready in 1, rdN_req_addr out DDR_ADDR_W, rdN_req_len out 13 (beats), for N = 1 and 2.
REQ-007 SHALL have loader config port conf_valid out 1, conf_ready in 1, and conf_mode 4, conf_ch_num 4, conf_row_num 4, conf_pix_num 4, conf_mask PE_NUM, conf_depool 1, all out.
REQ-008 SHALL have status outputs: tile_done out 1 (pulse), task_done out 1 (pulse), busy out 1.

Function
REQ-009 SHALL treat the task as conv when task_mode[2:1]==2'b01 and as FC otherwise.
REQ-010 SHALL accept a task only when task_valid && task_ready, and SHALL assert task_ready only in IDLE.
REQ-011 SHALL register all task fields at acceptance and SHALL drive conf_* from those registers, stable for the whole task.
REQ-012 SHALL implement states IDLE, CONF, REQ, WAIT, NEXT.
REQ-013 SHALL move IDLE->CONF on acceptance, with conf_valid high in the next cycle.
REQ-014 SHALL hold conf_valid in CONF until conf_valid && conf_ready, then move to REQ.
REQ-015 SHALL raise rd1_req_valid in REQ, and rd2_req_valid only in conv mode; each valid SHALL stay high until its own handshake, and the two handshakes are independent and may complete in either order or the same cycle.
REQ-016 SHALL set rdN_req_len to (ch+1)*(row+1)*(pix+1) in conv mode and to ch+1 in FC mode, computed at full 13-bit width with no truncation.
REQ-017 SHALL set rdN_req_addr to task_addrN + t*task_stride for tile t, accumulated by addition and wrapping modulo 2^DDR_ADDR_W.
REQ-018 SHALL move REQ->WAIT once all required read handshakes are done.
REQ-019 In WAIT, SHALL set a low_seen flag when conf_ready==0 and SHALL declare tile completion when conf_ready==1 with low_seen set (the loader drops ready after config and raises it at its last write).
REQ-020 SHALL clear low_seen on entry to CONF.
REQ-021 SHALL pulse tile_done for one cycle on tile completion and move to NEXT.
REQ-022 In NEXT, if tile index == task_tile_num, SHALL pulse task_done for one cycle and go to IDLE; otherwise it SHALL increment the tile index, advance both addresses by stride, and go to CONF.
REQ-023 SHALL drive busy = (state != IDLE).
REQ-024 SHALL ignore task_valid while busy; task inputs changing mid-task SHALL have no effect.
REQ-025 SHALL allow task_tile_num = 2^TILE_W-1 without overflow of the tile index compare.

Reset
REQ-026 On rst, SHALL go to IDLE and reset outputs to: task_ready=1, conf_valid=0, rd1/rd2_req_valid=0, tile_done=0, task_done=0, busy=0, tile index=0, low_seen=0.
REQ-027 Reset mid-task SHALL abandon the task in the same cycle with no further requests, and SHALL generate no completion pulses.
REQ-028 conf_* data and rdN_req_addr/len values SHALL be don't-care while their valids are low.

Verification
REQ-029 Conv task ch=3, row=1, pix=3, tiles=0, addr1=0x1000, addr2=0x8000 -> one conf handshake, rd1 {0x1000,32} and rd2 {0x8000,32}, then tile_done and task_done pulses after the conf_ready 0->1 transition.
REQ-030 FC task ch=7, tile_num=2, addr1=0x100, stride=0x40 -> rd1 addresses 0x100, 0x140, 0x180, len 8 each, rd2 never valid, 3 tile_done pulses, 1 task_done pulse.
REQ-031 rd1_req_ready held low for 5 cycles while rd2 completes immediately -> state stays REQ, rd2 valid drops after its handshake, WAIT entered only after rd1 handshake.
REQ-032 conf_ready held high for 3 cycles in WAIT before it drops -> no tile_done until it drops and rises again.
REQ-033 rst asserted in WAIT -> next cycle all valids 0, task_ready=1, no done pulse; a new task is accepted normally afterward.
REQ-034 addr1=0xFFFFFFF0, stride=0x20, 2 tiles -> second rd1 addr = 0x00000010.

Source files
------------

// File: rtl/dbuf_load_ctrl.sv
// dbuf_load_ctrl
// Sequences a data-buffer load task tile by tile. For each tile it hands the
// task configuration to the loader, issues one (FC) or two (conv) DDR read
// requests, then waits for the loader to signal completion through conf_ready.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   task_*               : task handshake and task fields (captured on accept)
//   rd1_req_*, rd2_req_* : DDR read requests {addr, len in beats}
//   conf_*               : loader configuration handshake, driven from the
//                          captured task fields
//   tile_done, task_done : single-cycle completion pulses
//   busy                 : high while a task is in flight
module dbuf_load_ctrl #(
    parameter int PE_NUM     = 32,
    parameter int DDR_ADDR_W = 32,
    parameter int TILE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  task_valid,
    output logic                  task_ready,
    input  logic [3:0]            task_mode,
    input  logic [3:0]            task_ch_num,
    input  logic [3:0]            task_row_num,
    input  logic [3:0]            task_pix_num,
    input  logic [PE_NUM-1:0]     task_mask,
    input  logic                  task_depool,
    input  logic [DDR_ADDR_W-1:0] task_addr1,
    input  logic [DDR_ADDR_W-1:0] task_addr2,
    input  logic [DDR_ADDR_W-1:0] task_stride,
    input  logic [TILE_W-1:0]     task_tile_num,

    output logic                  rd1_req_valid,
    input  logic                  rd1_req_ready,
    output logic [DDR_ADDR_W-1:0] rd1_req_addr,
    output logic [12:0]           rd1_req_len,

    output logic                  rd2_req_valid,
    input  logic                  rd2_req_ready,
    output logic [DDR_ADDR_W-1:0] rd2_req_addr,
    output logic [12:0]           rd2_req_len,

    output logic                  conf_valid,
    input  logic                  conf_ready,
    output logic [3:0]            conf_mode,
    output logic [3:0]            conf_ch_num,
    output logic [3:0]            conf_row_num,
    output logic [3:0]            conf_pix_num,
    output logic [PE_NUM-1:0]     conf_mask,
    output logic                  conf_depool,

    output logic                  tile_done,
    output logic                  task_done,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_REQ,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t state_q, state_d;

    logic [3:0]            mode_q, ch_q, row_q, pix_q;
    logic [PE_NUM-1:0]     mask_q;
    logic                  depool_q;
    logic                  conv_q;
    logic [12:0]           len_q;
    logic [DDR_ADDR_W-1:0] addr1_q, addr2_q, stride_q;
    logic [TILE_W-1:0]     tile_num_q, tile_idx_q;
    logic                  rd1_done_q, rd2_done_q;
    logic                  low_seen_q;
    logic                  tile_done_q, task_done_q;

    logic                  accept;
    logic                  rd1_hs, rd2_hs;
    logic                  tile_complete;
    logic                  last_tile;

    // Burst length at full 13-bit width: 16*16*16 = 4096 still fits.
    logic [12:0] ch_p1, row_p1, pix_p1, len_conv;
    logic        task_is_conv;

    assign ch_p1        = 13'(task_ch_num) + 13'd1;
    assign row_p1       = 13'(task_row_num) + 13'd1;
    assign pix_p1       = 13'(task_pix_num) + 13'd1;
    assign len_conv     = ch_p1 * row_p1 * pix_p1;
    assign task_is_conv = (task_mode[2:1] == 2'b01);

    assign conf_mode    = mode_q;
    assign conf_ch_num  = ch_q;
    assign conf_row_num = row_q;
    assign conf_pix_num = pix_q;
    assign conf_mask    = mask_q;
    assign conf_depool  = depool_q;

    assign rd1_req_addr = addr1_q;
    assign rd2_req_addr = addr2_q;
    assign rd1_req_len  = len_q;
    assign rd2_req_len  = len_q;

    assign tile_done    = tile_done_q;
    assign task_done    = task_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        task_ready    = (state_q == S_IDLE);
        conf_valid    = (state_q == S_CONF);
        rd1_req_valid = (state_q == S_REQ) && !rd1_done_q;
        rd2_req_valid = (state_q == S_REQ) && conv_q && !rd2_done_q;
        busy          = (state_q != S_IDLE);

        accept        = task_valid && task_ready;
        rd1_hs        = rd1_req_valid && rd1_req_ready;
        rd2_hs        = rd2_req_valid && rd2_req_ready;
        // Loader drops ready after taking the config and raises it again at
        // its last write; a high level alone is not completion.
        tile_complete = (state_q == S_WAIT) && conf_ready && low_seen_q;
        last_tile     = (tile_idx_q == tile_num_q);

        case (state_q)
            S_IDLE: if (accept) state_d = S_CONF;
            S_CONF: if (conf_ready) state_d = S_REQ;
            S_REQ: begin
                // FC tasks have no second stream, so rd2 counts as done.
                if ((rd1_done_q || rd1_hs) && (!conv_q || rd2_done_q || rd2_hs))
                    state_d = S_WAIT;
            end
            S_WAIT: if (tile_complete) state_d = S_NEXT;
            S_NEXT: state_d = last_tile ? S_IDLE : S_CONF;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= '0;
            ch_q        <= '0;
            row_q       <= '0;
            pix_q       <= '0;
            mask_q      <= '0;
            depool_q    <= 1'b0;
            conv_q      <= 1'b0;
            len_q       <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            stride_q    <= '0;
            tile_num_q  <= '0;
            tile_idx_q  <= '0;
            rd1_done_q  <= 1'b0;
            rd2_done_q  <= 1'b0;
            low_seen_q  <= 1'b0;
            tile_done_q <= 1'b0;
            task_done_q <= 1'b0;
        end else begin
            tile_done_q <= tile_complete;
            task_done_q <= (state_q == S_NEXT) && last_tile;

            if (accept) begin
                mode_q     <= task_mode;
                ch_q       <= task_ch_num;
                row_q      <= task_row_num;
                pix_q      <= task_pix_num;
                mask_q     <= task_mask;
                depool_q   <= task_depool;
                conv_q     <= task_is_conv;
                len_q      <= task_is_conv ? len_conv : ch_p1;
                addr1_q    <= task_addr1;
                addr2_q    <= task_addr2;
                stride_q   <= task_stride;
                tile_num_q <= task_tile_num;
                tile_idx_q <= '0;
                low_seen_q <= 1'b0;
            end

            if (state_q == S_CONF && conf_ready) begin
                rd1_done_q <= 1'b0;
                rd2_done_q <= 1'b0;
            end

            if (state_q == S_REQ) begin
                if (rd1_hs) rd1_done_q <= 1'b1;
                if (rd2_hs) rd2_done_q <= 1'b1;
            end

            if (state_q == S_WAIT && !conf_ready) begin
                low_seen_q <= 1'b1;
            end

            if (state_q == S_NEXT && !last_tile) begin
                tile_idx_q <= tile_idx_q + TILE_W'(1);
                addr1_q    <= addr1_q + stride_q;
                addr2_q    <= addr2_q + stride_q;
                low_seen_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dbuf_load_ctrl.sv
module tb_dbuf_load_ctrl;

    localparam int PE_NUM     = 32;
    localparam int DDR_ADDR_W = 32;
    localparam int TILE_W     = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        task_valid;
    logic        task_ready;
    logic [3:0]  task_mode, task_ch_num, task_row_num, task_pix_num;
    logic [31:0] task_mask;
    logic        task_depool;
    logic [31:0] task_addr1, task_addr2, task_stride;
    logic [7:0]  task_tile_num;
    logic        rd1_req_valid, rd1_req_ready;
    logic [31:0] rd1_req_addr;
    logic [12:0] rd1_req_len;
    logic        rd2_req_valid, rd2_req_ready;
    logic [31:0] rd2_req_addr;
    logic [12:0] rd2_req_len;
    logic        conf_valid, conf_ready;
    logic [3:0]  conf_mode, conf_ch_num, conf_row_num, conf_pix_num;
    logic [31:0] conf_mask;
    logic        conf_depool;
    logic        tile_done, task_done, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbuf_load_ctrl #(
        .PE_NUM    (PE_NUM),
        .DDR_ADDR_W(DDR_ADDR_W),
        .TILE_W    (TILE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .task_valid   (task_valid),
        .task_ready   (task_ready),
        .task_mode    (task_mode),
        .task_ch_num  (task_ch_num),
        .task_row_num (task_row_num),
        .task_pix_num (task_pix_num),
        .task_mask    (task_mask),
        .task_depool  (task_depool),
        .task_addr1   (task_addr1),
        .task_addr2   (task_addr2),
        .task_stride  (task_stride),
        .task_tile_num(task_tile_num),
        .rd1_req_valid(rd1_req_valid),
        .rd1_req_ready(rd1_req_ready),
        .rd1_req_addr (rd1_req_addr),
        .rd1_req_len  (rd1_req_len),
        .rd2_req_valid(rd2_req_valid),
        .rd2_req_ready(rd2_req_ready),
        .rd2_req_addr (rd2_req_addr),
        .rd2_req_len  (rd2_req_len),
        .conf_valid   (conf_valid),
        .conf_ready   (conf_ready),
        .conf_mode    (conf_mode),
        .conf_ch_num  (conf_ch_num),
        .conf_row_num (conf_row_num),
        .conf_pix_num (conf_pix_num),
        .conf_mask    (conf_mask),
        .conf_depool  (conf_depool),
        .tile_done    (tile_done),
        .task_done    (task_done),
        .busy         (busy)
    );

    typedef struct {
        logic [3:0]  mode;
        logic [3:0]  ch;
        logic [3:0]  row;
        logic [3:0]  pix;
        logic [31:0] mask;
        logic        depool;
        logic [7:0]  tiles;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] stride;
        logic [12:0] len;   // hand-computed expected burst length
        bit          conv;  // hand-computed expected mode decode
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_task(input vec_t v);
        task_mode     = v.mode;
        task_ch_num   = v.ch;
        task_row_num  = v.row;
        task_pix_num  = v.pix;
        task_mask     = v.mask;
        task_depool   = v.depool;
        task_tile_num = v.tiles;
        task_addr1    = v.a1;
        task_addr2    = v.a2;
        task_stride   = v.stride;
        task_valid    = 1'b1;
    endtask

    // Accept a task, then leave task_valid high with scrambled fields to show
    // that inputs are ignored while busy.
    task automatic accept_task(input vec_t v);
        drive_task(v);
        step();
        task_mode     = ~v.mode;
        task_ch_num   = ~v.ch;
        task_row_num  = ~v.row;
        task_tile_num = v.tiles + 8'd3;
        task_addr1    = ~v.a1;
        task_addr2    = ~v.a2;
        task_stride   = v.stride + 32'h4;
    endtask

    // Cooperative loader/DDR: readies high, conf_ready low for two WAIT cycles.
    task automatic run_vec(input int idx);
        vec_t v;
        int rd1n, rd2n, confn, tilen, donen, wc;
        bit finished;
        logic [31:0] e;
        v = vecs[idx];
        rd1n = 0; rd2n = 0; confn = 0; tilen = 0; donen = 0; wc = 0;
        finished = 0;
        conf_ready = 1'b1;
        rd1_req_ready = 1'b1;
        rd2_req_ready = 1'b1;
        accept_task(v);
        chk($sformatf("v%0d_conf_after_accept", idx), conf_valid, 1'b1);
        for (int c = 0; c < 400 && !finished; c++) begin
            if (conf_valid) begin
                confn++;
                chk($sformatf("v%0d_conf_fields", idx),
                    {conf_mode, conf_ch_num, conf_row_num, conf_pix_num, conf_depool, conf_mask},
                    {v.mode, v.ch, v.row, v.pix, v.depool, v.mask});
            end
            if (rd1_req_valid) begin
                e = v.a1 + 32'(rd1n) * v.stride;
                chk($sformatf("v%0d_rd1_t%0d", idx, rd1n), {rd1_req_addr, rd1_req_len}, {e, v.len});
                rd1n++;
            end
            if (rd2_req_valid) begin
                e = v.a2 + 32'(rd2n) * v.stride;
                chk($sformatf("v%0d_rd2_t%0d", idx, rd2n), {rd2_req_addr, rd2_req_len}, {e, v.len});
                rd2n++;
            end
            if (tile_done) tilen++;
            if (task_done) begin
                donen++;
                finished = 1;
            end
            if (busy && !conf_valid && !rd1_req_valid && !rd2_req_valid) begin
                wc++;
                conf_ready = (wc >= 3);
            end else begin
                wc = 0;
                conf_ready = 1'b1;
            end
            if (finished) task_valid = 1'b0;
            else step();
        end
        chk($sformatf("v%0d_finished", idx), finished, 1'b1);
        chk($sformatf("v%0d_rd1_count", idx), rd1n, int'(v.tiles) + 1);
        chk($sformatf("v%0d_rd2_count", idx), rd2n, v.conv ? int'(v.tiles) + 1 : 0);
        chk($sformatf("v%0d_conf_count", idx), confn, int'(v.tiles) + 1);
        chk($sformatf("v%0d_tile_done_count", idx), tilen, int'(v.tiles) + 1);
        chk($sformatf("v%0d_task_done_count", idx), donen, 1);
        chk($sformatf("v%0d_idle_at_done", idx), {busy, task_ready}, 2'b01);
        task_valid = 1'b0;
        step();
        chk($sformatf("v%0d_done_pulse_width", idx), {task_done, tile_done}, 2'b00);
    endtask

    initial begin
        // mode ch row pix mask depool tiles a1 a2 stride len conv
        vecs[0] = '{4'b0010, 4'd3,  4'd1,  4'd3,  32'hDEAD_BEEF, 1'b1, 8'd0,
                    32'h0000_1000, 32'h0000_8000, 32'h0000_0000, 13'd32,   1'b1};
        vecs[1] = '{4'b0000, 4'd7,  4'd2,  4'd5,  32'h0000_FFFF, 1'b0, 8'd2,
                    32'h0000_0100, 32'h0000_0200, 32'h0000_0040, 13'd8,    1'b0};
        vecs[2] = '{4'b0100, 4'd0,  4'd0,  4'd0,  32'h8000_0001, 1'b0, 8'd1,
                    32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0020, 13'd1,    1'b0};
        vecs[3] = '{4'b1011, 4'd15, 4'd15, 4'd15, 32'hFFFF_FFFF, 1'b1, 8'd1,
                    32'h0000_0000, 32'h0000_0010, 32'h0000_1000, 13'd4096, 1'b1};
        vecs[4] = '{4'b0110, 4'd2,  4'd5,  4'd5,  32'h1234_5678, 1'b1, 8'd0,
                    32'h0000_0A00, 32'h0000_0B00, 32'h0000_0000, 13'd3,    1'b0};

        rst = 1'b1;
        task_valid = 1'b0;
        task_mode = '0; task_ch_num = '0; task_row_num = '0; task_pix_num = '0;
        task_mask = '0; task_depool = 1'b0; task_addr1 = '0; task_addr2 = '0;
        task_stride = '0; task_tile_num = '0;
        rd1_req_ready = 1'b0; rd2_req_ready = 1'b0; conf_ready = 1'b0;
        step();
        step();
        chk("reset_outputs",
            {task_ready, conf_valid, rd1_req_valid, rd2_req_valid, tile_done, task_done, busy},
            7'b1000000);
        rst = 1'b0;
        step();
        chk("idle_after_reset", {task_ready, busy}, 2'b10);

        for (int i = 0; i < 5; i++) run_vec(i);

        // rd1 stalled for five cycles while rd2 completes at once.
        rd1_req_ready = 1'b0;
        rd2_req_ready = 1'b1;
        conf_ready    = 1'b1;
        accept_task(vecs[0]);
        step();
        chk("stall_req_entry", {rd1_req_valid, rd2_req_valid}, 2'b11);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("stall_c%0d", c), {rd1_req_valid, rd2_req_valid, busy, conf_valid}, 4'b1010);
        end
        rd1_req_ready = 1'b1;
        step();
        chk("stall_wait_entry", {rd1_req_valid, rd2_req_valid, busy, tile_done}, 4'b0010);
        conf_ready = 1'b0;
        step();
        chk("stall_low", tile_done, 1'b0);
        conf_ready = 1'b1;
        step();
        chk("stall_tile_done", tile_done, 1'b1);
        task_valid = 1'b0;
        step();
        chk("stall_task_done", {task_done, tile_done, busy}, 3'b100);

        // conf_ready high on WAIT entry is not completion.
        accept_task(vecs[4]);
        task_valid = 1'b0;
        step();
        step();
        chk("hold_wait_entry", {rd1_req_valid, busy}, 2'b01);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hold_high_c%0d", c), tile_done, 1'b0);
        end
        conf_ready = 1'b0;
        step();
        chk("hold_low", tile_done, 1'b0);
        conf_ready = 1'b1;
        step();
        chk("hold_tile_done", tile_done, 1'b1);
        step();
        chk("hold_task_done", task_done, 1'b1);

        // Reset in WAIT with a completion condition pending.
        accept_task(vecs[1]);
        task_valid = 1'b0;
        step();
        step();
        conf_ready = 1'b0;
        step();
        rst = 1'b1;
        conf_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait_outputs",
            {task_ready, conf_valid, rd1_req_valid, rd2_req_valid, tile_done, task_done, busy},
            7'b1000000);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rst_quiet_c%0d", c), {tile_done, task_done, busy}, 3'b000);
        end
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
